// File: rtl/alu_arb.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arb
//  Description : Round-robin arbiter that lets two requesters share one
//                combinational ALU, one operation at a time.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_arb #(
    parameter logic PRIO_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        Req0_Valid,
    output logic        Req0_Ready,
    input  logic [31:0] Req0_A,
    input  logic [31:0] Req0_B,
    input  logic [3:0]  Req0_Func,

    input  logic        Req1_Valid,
    output logic        Req1_Ready,
    input  logic [31:0] Req1_A,
    input  logic [31:0] Req1_B,
    input  logic [3:0]  Req1_Func,

    output logic        Rsp0_Valid,
    input  logic        Rsp0_Ready,
    output logic        Rsp1_Valid,
    input  logic        Rsp1_Ready,
    output logic [31:0] Rsp_Data,
    output logic        Rsp_Zero,
    output logic        Rsp_OverFlow,

    output logic [31:0] ALU_DA,
    output logic [31:0] ALU_DB,
    output logic [3:0]  ALU_Func,
    input  logic [31:0] ALU_DC,
    input  logic        ALU_Zero,
    input  logic        ALU_OverFlow
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       r_prio;
    logic       r_gnt;
    logic       w_gnt_id;
    logic       w_idle;
    logic       w_accept;
    logic       w_rsp_hs;

    // Requester that would win if the arbiter is idle this cycle
    always_comb begin
        w_gnt_id = 1'b0;
        if (Req0_Valid && Req1_Valid) begin
            w_gnt_id = r_prio;
        end else if (Req1_Valid) begin
            w_gnt_id = 1'b1;
        end
    end

    assign w_idle     = (r_state == S_IDLE);
    assign Req0_Ready = w_idle && Req0_Valid && !w_gnt_id;
    assign Req1_Ready = w_idle && Req1_Valid &&  w_gnt_id;
    assign w_accept   = Req0_Ready || Req1_Ready;

    assign Rsp0_Valid = (r_state == S_RESP) && !r_gnt;
    assign Rsp1_Valid = (r_state == S_RESP) &&  r_gnt;
    assign w_rsp_hs   = (Rsp0_Valid && Rsp0_Ready) || (Rsp1_Valid && Rsp1_Ready);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_EXEC;
            S_EXEC:  w_state_nxt = S_RESP;
            S_RESP:  if (w_rsp_hs) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_prio  <= PRIO_INIT;
            r_gnt   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_gnt <= w_gnt_id;
            end
            // Priority passes to the other requester once a result is consumed
            if (w_rsp_hs) begin
                r_prio <= !r_gnt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ALU_DA       <= 32'd0;
            ALU_DB       <= 32'd0;
            ALU_Func     <= 4'd0;
            Rsp_Data     <= 32'd0;
            Rsp_Zero     <= 1'b0;
            Rsp_OverFlow <= 1'b0;
        end else begin
            if (w_accept) begin
                ALU_DA   <= w_gnt_id ? Req1_A    : Req0_A;
                ALU_DB   <= w_gnt_id ? Req1_B    : Req0_B;
                ALU_Func <= w_gnt_id ? Req1_Func : Req0_Func;
            end
            if (r_state == S_EXEC) begin
                Rsp_Data     <= ALU_DC;
                Rsp_Zero     <= ALU_Zero;
                Rsp_OverFlow <= ALU_OverFlow;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_arb
//  Description : Self-checking bench for alu_arb with a transaction-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        Req0_Valid, Req0_Ready, Req1_Valid, Req1_Ready;
    logic [31:0] Req0_A, Req0_B, Req1_A, Req1_B;
    logic [3:0]  Req0_Func, Req1_Func;
    logic        Rsp0_Valid, Rsp0_Ready, Rsp1_Valid, Rsp1_Ready;
    logic [31:0] Rsp_Data;
    logic        Rsp_Zero, Rsp_OverFlow;
    logic [31:0] ALU_DA, ALU_DB, ALU_DC;
    logic [3:0]  ALU_Func;
    logic        ALU_Zero, ALU_OverFlow;

    int tests = 0;
    int fails = 0;

    alu_arb #(.PRIO_INIT(1'b0)) dut (
        .clk(clk), .rst(rst),
        .Req0_Valid(Req0_Valid), .Req0_Ready(Req0_Ready), .Req0_A(Req0_A), .Req0_B(Req0_B), .Req0_Func(Req0_Func),
        .Req1_Valid(Req1_Valid), .Req1_Ready(Req1_Ready), .Req1_A(Req1_A), .Req1_B(Req1_B), .Req1_Func(Req1_Func),
        .Rsp0_Valid(Rsp0_Valid), .Rsp0_Ready(Rsp0_Ready), .Rsp1_Valid(Rsp1_Valid), .Rsp1_Ready(Rsp1_Ready),
        .Rsp_Data(Rsp_Data), .Rsp_Zero(Rsp_Zero), .Rsp_OverFlow(Rsp_OverFlow),
        .ALU_DA(ALU_DA), .ALU_DB(ALU_DB), .ALU_Func(ALU_Func),
        .ALU_DC(ALU_DC), .ALU_Zero(ALU_Zero), .ALU_OverFlow(ALU_OverFlow)
    );

    always #5 clk = ~clk;

    // Reference ALU: {overflow, zero, result}; unknown codes give ~(a^b)
    function automatic logic [33:0] alu_f(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        ov;
        ov = 1'b0;
        case (f)
            4'd1: r = a + b;
            4'd2: begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
            4'd3: begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
            4'd5: r = a & b;
            4'd6: r = a | b;
            default: r = ~(a ^ b);
        endcase
        return {ov, (r == 32'd0), r};
    endfunction

    assign {ALU_OverFlow, ALU_Zero, ALU_DC} = alu_f(ALU_Func, ALU_DA, ALU_DB);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: an operation is "in flight" for m_age cycles after acceptance
    bit          m_ok = 1'b0;
    bit          m_busy, m_owner, m_prio, m_zero, m_ovf;
    int          m_age;
    logic [31:0] m_da, m_db, m_res;
    logic [3:0]  m_func;

    function automatic bit exp_rdy(input bit id);
        if (m_busy) return 1'b0;
        if (!id) return Req0_Valid && (!Req1_Valid || !m_prio);
        return Req1_Valid && (!Req0_Valid || m_prio);
    endfunction

    always @(posedge clk) begin : model
        bit a0, a1;
        a0 = exp_rdy(1'b0);
        a1 = exp_rdy(1'b1);
        if (rst) begin
            m_ok = 1'b1; m_busy = 1'b0; m_age = 0; m_owner = 1'b0; m_prio = 1'b0;
            m_da = '0; m_db = '0; m_func = '0; m_res = '0; m_zero = 1'b0; m_ovf = 1'b0;
        end else if (!m_busy) begin
            if (a0 || a1) begin
                m_owner = a1;
                m_da    = a1 ? Req1_A : Req0_A;
                m_db    = a1 ? Req1_B : Req0_B;
                m_func  = a1 ? Req1_Func : Req0_Func;
                m_busy  = 1'b1;
                m_age   = 1;
            end
        end else if (m_age == 1) begin
            {m_ovf, m_zero, m_res} = alu_f(m_func, m_da, m_db);
            m_age = 2;
        end else if (m_owner ? Rsp1_Ready : Rsp0_Ready) begin
            m_busy = 1'b0;
            m_prio = !m_owner;
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("req0_ready", 32'(Req0_Ready), 32'(exp_rdy(1'b0)));
            chk("req1_ready", 32'(Req1_Ready), 32'(exp_rdy(1'b1)));
            chk("rsp0_valid", 32'(Rsp0_Valid), 32'(m_busy && m_age >= 2 && !m_owner));
            chk("rsp1_valid", 32'(Rsp1_Valid), 32'(m_busy && m_age >= 2 &&  m_owner));
            chk("alu_da", ALU_DA, m_da);
            chk("alu_db", ALU_DB, m_db);
            chk("alu_func", 32'(ALU_Func), 32'(m_func));
            chk("rsp_data", Rsp_Data, m_res);
            chk("rsp_zero", 32'(Rsp_Zero), 32'(m_zero));
            chk("rsp_ovf", 32'(Rsp_OverFlow), 32'(m_ovf));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    bit found;
    int lat;
    int grants[$];
    bit exp_g[4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        Req0_Valid = 0; Req1_Valid = 0; Rsp0_Ready = 0; Rsp1_Ready = 0;
        Req0_A = 0; Req0_B = 0; Req0_Func = 0; Req1_A = 0; Req1_B = 0; Req1_Func = 0;
        tick();
        pulse_rst();
        @(negedge clk);
        chk("rst_alu_da", ALU_DA, 32'd0);
        chk("rst_rsp_data", Rsp_Data, 32'd0);
        chk("rst_rsp0_valid", 32'(Rsp0_Valid), 32'd0);

        // Single add, latency of two cycles
        tick();
        Req0_Valid = 1; Req0_A = 32'd5; Req0_B = 32'd3; Req0_Func = 4'd1; Rsp0_Ready = 1;
        @(negedge clk);
        chk("t1_ready", 32'(Req0_Ready), 32'd1);
        tick();
        Req0_Valid = 0;
        lat = 1; found = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (Rsp0_Valid) begin found = 1; break; end
            tick();
            lat++;
        end
        chk("t1_found", 32'(found), 32'd1);
        chk("t1_latency", 32'(lat), 32'd2);
        chk("t1_data", Rsp_Data, 32'd8);
        chk("t1_zero", 32'(Rsp_Zero), 32'd0);
        chk("t1_ovf", 32'(Rsp_OverFlow), 32'd0);

        // Contention with round-robin
        tick();
        pulse_rst();
        Req0_Valid = 1; Req0_A = 32'd7; Req0_B = 32'd7; Req0_Func = 4'd3;
        Req1_Valid = 1; Req1_A = 32'hFFFF0000; Req1_B = 32'h0F0F0F0F; Req1_Func = 4'd5;
        Rsp0_Ready = 1; Rsp1_Ready = 1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (Req0_Ready) grants.push_back(0);
            if (Req1_Ready) grants.push_back(1);
            if (Rsp0_Valid) begin
                chk("t2_r0_data", Rsp_Data, 32'd0);
                chk("t2_r0_zero", 32'(Rsp_Zero), 32'd1);
            end
            if (Rsp1_Valid) chk("t2_r1_data", Rsp_Data, 32'h0F0F0000);
            tick();
        end
        Req0_Valid = 0; Req1_Valid = 0;
        chk("t2_ngrants", 32'(grants.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < grants.size()) chk("t2_grant", 32'(grants[i]), 32'(exp_g[i]));
        end

        // Backpressure on requester 1 with an overflowing add
        pulse_rst();
        Req1_Valid = 1; Req1_A = 32'h7FFFFFFF; Req1_B = 32'd1; Req1_Func = 4'd2;
        Rsp0_Ready = 0; Rsp1_Ready = 0;
        @(negedge clk);
        chk("t3_req1_ready", 32'(Req1_Ready), 32'd1);
        tick();
        Req1_Valid = 0;
        Req0_Valid = 1; Req0_A = 32'h10; Req0_B = 32'h20; Req0_Func = 4'd6;
        @(negedge clk);
        chk("t3_exec_req0_ready", 32'(Req0_Ready), 32'd0);
        tick();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t3_hold_valid", 32'(Rsp1_Valid), 32'd1);
            chk("t3_hold_data", Rsp_Data, 32'h80000000);
            chk("t3_hold_ovf", 32'(Rsp_OverFlow), 32'd1);
            chk("t3_hold_req0", 32'(Req0_Ready), 32'd0);
            tick();
        end
        Rsp1_Ready = 1; Rsp0_Ready = 1;
        @(negedge clk);
        chk("t3_hs_req0", 32'(Req0_Ready), 32'd0);
        tick();
        Rsp1_Ready = 0;
        @(negedge clk);
        chk("t3_req0_after", 32'(Req0_Ready), 32'd1);
        tick();
        Req0_Valid = 0;
        repeat (4) tick();

        // Reset during EXEC drops the operation and restores priority
        Req0_Valid = 1; Req0_A = 32'd1; Req0_B = 32'd2; Req0_Func = 4'd1;
        tick();
        Req0_Valid = 0;
        rst = 1;
        tick();
        rst = 0;
        @(negedge clk);
        chk("t4_alu_da", ALU_DA, 32'd0);
        chk("t4_alu_func", 32'(ALU_Func), 32'd0);
        chk("t4_rsp_data", Rsp_Data, 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t4_no_rsp", 32'(Rsp0_Valid), 32'd0);
            tick();
        end
        Req0_Valid = 1; Req0_A = 32'd1; Req0_B = 32'd2; Req0_Func = 4'hF;
        Req1_Valid = 1; Req1_A = 32'd3; Req1_B = 32'd4; Req1_Func = 4'd1;
        @(negedge clk);
        chk("t4_prio_req0", 32'(Req0_Ready), 32'd1);
        chk("t4_prio_req1", 32'(Req1_Ready), 32'd0);
        tick();
        Req0_Valid = 0; Req1_Valid = 0;
        tick();
        @(negedge clk);
        chk("t4_rsp_valid", 32'(Rsp0_Valid), 32'd1);
        chk("t4_unknown_func", Rsp_Data, 32'hFFFFFFFC);
        tick();
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
